// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises an 8N1 idle-high line, samples at mid-bit and hands
// bytes out over valid/ready, flagging stop-bit framing errors and overruns.
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0]  HALF_CNT = 8'(HALF);
  localparam logic [7:0]  LAST_CNT = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic       rx_s;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       line_ok_q, line_ok_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign rx_s = rx;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = rx;
    end

    // Resets to idle-high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '1;
      else       sync_q <= sync_d;
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    line_ok_d   = line_ok_q;

    if (valid_q && data_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_s) begin
          line_ok_d = 1'b1;
        end else if (line_ok_q) begin
          bit_d = 3'd0;
          if (HALF == 0) begin
            state_d = StData;
            cnt_d   = 8'd0;
          end else begin
            state_d = StStart;
            cnt_d   = 8'd1;
          end
        end
      end
      StStart: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = 8'd0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StData: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = 8'd0;
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStop: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            line_ok_d   = 1'b0;
          end else if (!valid_q || data_ready) begin
            // A same-cycle consume is overridden by the new byte.
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      line_ok_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      line_ok_q   <= line_ok_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 1, 4 and 16 clocks per bit.
module tb_uart_rx_deframer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       rx1 = 1'b1, rx4 = 1'b1, rx16 = 1'b1;
  logic       rdy1 = 1'b0, rdy4 = 1'b0, rdy16 = 1'b0;
  logic [7:0] dout1, dout4, dout16;
  logic       dv1, dv4, dv16, fe1, fe4, fe16, ov1, ov4, ov16, busy1, busy4, busy16;

  uart_rx_deframer #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .data_out(dout1), .data_valid(dv1),
    .data_ready(rdy1), .frame_err(fe1), .overrun(ov1), .busy(busy1)
  );
  uart_rx_deframer #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset(reset), .rx(rx4), .data_out(dout4), .data_valid(dv4),
    .data_ready(rdy4), .frame_err(fe4), .overrun(ov4), .busy(busy4)
  );
  uart_rx_deframer #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .reset(reset), .rx(rx16), .data_out(dout16), .data_valid(dv16),
    .data_ready(rdy16), .frame_err(fe16), .overrun(ov16), .busy(busy16)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc4 = 0, fe4_cnt = 0, ov4_cnt = 0, v16_cnt = 0, fe16_cnt = 0, fe1_cnt = 0;
  logic [7:0] last4 = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv4 && rdy4) begin
      acc4  <= acc4 + 1;
      last4 <= dout4;
    end
    if (fe4)  fe4_cnt  <= fe4_cnt + 1;
    if (ov4)  ov4_cnt  <= ov4_cnt + 1;
    if (dv16) v16_cnt  <= v16_cnt + 1;
    if (fe16) fe16_cnt <= fe16_cnt + 1;
    if (fe1)  fe1_cnt  <= fe1_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      1:       rx1 = v;
      4:       rx4 = v;
      default: rx16 = v;
    endcase
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the stop level stays on the line.
  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(sel, bits[i]);
      wait_cyc(sel);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0, lat, a0, f0, o0;

    vecs[0] = '{data: 8'h00, stop: 1'b1, exp_acc: 1, exp_fe: 0};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_acc: 1, exp_fe: 0};
    vecs[2] = '{data: 8'h81, stop: 1'b1, exp_acc: 1, exp_fe: 0};
    vecs[3] = '{data: 8'h5A, stop: 1'b0, exp_acc: 0, exp_fe: 1};
    vecs[4] = '{data: 8'h7E, stop: 1'b1, exp_acc: 1, exp_fe: 0};

    #2;
    check("reset_dut1", {dout1, dv1, fe1, ov1, busy1}, 32'h0);
    check("reset_dut4", {dout4, dv4, fe4, ov4, busy4}, 32'h0);
    check("reset_dut16", {dout16, dv16, fe16, ov16, busy16}, 32'h0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(3);

    // 1 clock per bit: latency and byte
    rdy1 = 1'b1;
    t0 = cyc;
    send_frame(1, 8'hA5, 1'b1);
    set_rx(1, 1'b1);
    lat = 999;
    for (int k = 0; k < 40; k++) begin
      if (dv1) begin
        lat = cyc - t0;
        break;
      end
      wait_cyc(1);
    end
    check("a5_latency", lat, 12);
    check("a5_data", dout1, 8'hA5);
    check("a5_no_frame_err", fe1_cnt, 0);

    // False start at 16 clocks per bit
    set_rx(16, 1'b0);
    wait_cyc(5);
    check("false_start_busy", busy16, 1);
    set_rx(16, 1'b1);
    wait_cyc(20);
    check("false_start_idle", busy16, 0);
    check("false_start_no_valid", v16_cnt, 0);
    check("false_start_no_ferr", fe16_cnt, 0);

    // Table of frames at 4 clocks per bit, consumer always ready
    rdy4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a0 = acc4;
      f0 = fe4_cnt;
      send_frame(4, vecs[i].data, vecs[i].stop);
      set_rx(4, 1'b1);
      wait_cyc(6);
      check($sformatf("vec%0d_accepted", i), acc4 - a0, vecs[i].exp_acc);
      check($sformatf("vec%0d_frame_err", i), fe4_cnt - f0, vecs[i].exp_fe);
      if (vecs[i].exp_acc != 0) check($sformatf("vec%0d_data", i), last4, vecs[i].data);
    end

    // Back-to-back frames with consumer stalled: overrun
    rdy4 = 1'b0;
    o0 = ov4_cnt;
    send_frame(4, 8'h3C, 1'b1);
    send_frame(4, 8'hC3, 1'b1);
    wait_cyc(5);
    check("overrun_held_data", dout4, 8'h3C);
    check("overrun_held_valid", dv4, 1);
    check("overrun_pulses", ov4_cnt - o0, 1);
    rdy4 = 1'b1;
    wait_cyc(1);
    rdy4 = 1'b0;
    wait_cyc(1);
    check("overrun_consumed", dv4, 0);

    // Framing error followed by a break; line must recover
    rdy4 = 1'b1;
    a0 = acc4;
    f0 = fe4_cnt;
    send_frame(4, 8'h55, 1'b0);
    wait_cyc(25);
    check("break_not_busy", busy4, 0);
    wait_cyc(25);
    set_rx(4, 1'b1);
    wait_cyc(10);
    check("break_one_ferr", fe4_cnt - f0, 1);
    check("break_nothing_decoded", acc4 - a0, 0);
    send_frame(4, 8'h0F, 1'b1);
    wait_cyc(6);
    check("after_break_accepted", acc4 - a0, 1);
    check("after_break_data", last4, 8'h0F);

    // Asynchronous reset in the middle of data bit 3
    set_rx(4, 1'b0);
    wait_cyc(4);
    for (int i = 0; i < 3; i++) begin
      set_rx(4, 1'b1);
      wait_cyc(4);
    end
    set_rx(4, 1'b0);
    wait_cyc(2);
    #2 reset = 1'b1;
    #1;
    check("midframe_reset_outs", {dout4, dv4, fe4, ov4, busy4}, 32'h0);
    set_rx(4, 1'b1);
    wait_cyc(3);
    #2 reset = 1'b0;
    wait_cyc(3);
    check("after_reset_outs", {dout4, dv4, fe4, ov4, busy4}, 32'h0);
    a0 = acc4;
    send_frame(4, 8'hFF, 1'b1);
    wait_cyc(6);
    check("after_reset_accepted", acc4 - a0, 1);
    check("after_reset_data", last4, 8'hFF);

    // Consume and completion in the same cycle
    rdy4 = 1'b0;
    o0 = ov4_cnt;
    send_frame(4, 8'h12, 1'b1);
    wait_cyc(3);
    fork
      send_frame(4, 8'h34, 1'b1);
      begin
        repeat (39) @(posedge clk);
        #2;
        check("swap_before", {dv4, dout4}, {1'b1, 8'h12});
        rdy4 = 1'b1;
        @(posedge clk);
        #2;
        check("swap_after", {dv4, dout4}, {1'b1, 8'h34});
        @(posedge clk);
        #2;
        check("swap_consumed", dv4, 0);
      end
    join
    check("swap_no_overrun", ov4_cnt - o0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
